// File: rtl/num_matrix_loader.sv
// -----------------------------------------------------------------------------
// num_matrix_loader
//
// Reads a matrix out of the separator's number RAM and streams its elements
// with a valid/ready handshake. The RAM layout is {rows, cols, e0, e1, ...},
// where the elements are stored row-major.
//
// Optional build macro:
//   LOADER_TRANSPOSE_EN - emit elements column-major instead of row-major.
//                         The RAM addressing is the same in both modes.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sep_done         separator finished; a rising edge in IDLE starts a load
//   sep_invalid      separator rejected the payload (sampled on the start edge)
//   sep_num_count    number of words the separator stored
//   rd_addr/rd_data  number-RAM read port (data valid 1 cycle after address)
//   m_data/m_row/m_col/m_valid/m_ready/m_last
//                    element stream
//   dim_rows/dim_cols latched header dimensions
//   clear            returns from DONE/ERR to IDLE
//   busy/done/error/err_code
//                    status (01 invalid, 10 bad dims, 11 count mismatch)
// -----------------------------------------------------------------------------
module num_matrix_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_DIM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sep_done,
    input  logic                  sep_invalid,
    input  logic [10:0]           sep_num_count,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [7:0]            m_row,
    output logic [7:0]            m_col,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            dim_rows,
    output logic [7:0]            dim_cols,
    input  logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, CHECK, FETCH, CAP, OUT, DONE, ERR
    } state_t;

    state_t                  r_state;
    logic                    r_sep_prev;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [7:0]              r_row;
    logic [7:0]              r_col;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic [7:0]              r_dim_rows;
    logic [7:0]              r_dim_cols;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [1:0]              r_err_code;

    logic                    w_start;
    logic [7:0]              w_cols_hdr;
    logic [15:0]             w_prod_hdr;
    logic                    w_dim_bad;
    logic                    w_cnt_bad;
    logic                    w_row_end;
    logic                    w_col_end;
    logic                    w_is_last;
    logic [7:0]              w_nrow;
    logic [7:0]              w_ncol;
    logic [15:0]             w_nprod;
    logic [16:0]             w_next_addr;

    assign w_start = sep_done & ~r_sep_prev;

    // The column count arrives on rd_data during CHECK, so the checks use it
    // directly while it is being latched into dim_cols.
    assign w_cols_hdr = rd_data[7:0];
    assign w_prod_hdr = {8'b0, r_dim_rows} * {8'b0, w_cols_hdr};
    assign w_dim_bad  = (r_dim_rows == 8'd0) || (w_cols_hdr == 8'd0) ||
                        (32'(r_dim_rows) > MAX_DIM) || (32'(w_cols_hdr) > MAX_DIM);
    assign w_cnt_bad  = {6'b0, sep_num_count} != (17'd2 + {1'b0, w_prod_hdr});

    assign w_row_end = (r_row == r_dim_rows - 8'd1);
    assign w_col_end = (r_col == r_dim_cols - 8'd1);
    assign w_is_last = w_row_end && w_col_end;

`ifdef LOADER_TRANSPOSE_EN
    assign w_nrow = w_row_end ? 8'd0 : r_row + 8'd1;
    assign w_ncol = w_row_end ? r_col + 8'd1 : r_col;
`else
    assign w_ncol = w_col_end ? 8'd0 : r_col + 8'd1;
    assign w_nrow = w_col_end ? r_row + 8'd1 : r_row;
`endif

    // Address of the element that follows the current handshake.
    assign w_nprod     = {8'b0, w_nrow} * {8'b0, r_dim_cols};
    assign w_next_addr = 17'd2 + {1'b0, w_nprod} + {9'b0, w_ncol};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sep_prev <= 1'b0;
            r_rd_addr  <= '0;
            r_m_data   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_dim_rows <= '0;
            r_dim_cols <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= '0;
        end else begin
            // Tracked in every state, so edges outside IDLE are consumed.
            r_sep_prev <= sep_done;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_row <= '0;
                        r_col <= '0;
                        if (sep_invalid) begin
                            r_state    <= ERR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'b01;
                        end else begin
                            r_state    <= HDR0;
                            r_busy     <= 1'b1;
                            r_dim_rows <= '0;
                            r_dim_cols <= '0;
                            r_rd_addr  <= '0;
                        end
                    end
                end
                HDR0: begin
                    r_rd_addr <= ADDR_WIDTH'(1);
                    r_state   <= HDR1;
                end
                HDR1: begin
                    r_dim_rows <= rd_data[7:0];
                    r_state    <= CHECK;
                end
                CHECK: begin
                    r_dim_cols <= w_cols_hdr;
                    if (w_dim_bad) begin
                        r_state    <= ERR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'b10;
                    end else if (w_cnt_bad) begin
                        r_state    <= ERR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'b11;
                    end else begin
                        r_state   <= FETCH;
                        r_rd_addr <= ADDR_WIDTH'(2);
                    end
                end
                FETCH: begin
                    r_state <= CAP;
                end
                CAP: begin
                    r_m_data  <= rd_data;
                    r_m_last  <= w_is_last;
                    r_m_valid <= 1'b1;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (w_is_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row     <= w_nrow;
                            r_col     <= w_ncol;
                            r_rd_addr <= w_next_addr[ADDR_WIDTH-1:0];
                            r_state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (clear) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                ERR: begin
                    if (clear) begin
                        r_state    <= IDLE;
                        r_error    <= 1'b0;
                        r_err_code <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr  = r_rd_addr;
    assign m_data   = r_m_data;
    assign m_row    = r_row;
    assign m_col    = r_col;
    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign dim_rows = r_dim_rows;
    assign dim_cols = r_dim_cols;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_num_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_num_matrix_loader
//
// Directed bench for num_matrix_loader. A behavioural RAM answers rd_addr one
// cycle later; expected elements are queued from the RAM contents when a load
// is started and popped as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_num_matrix_loader;

    localparam int DW = 32;
    localparam int AW = 11;

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    r;
        logic [7:0]    c;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sep_done = 1'b0;
    logic          sep_invalid = 1'b0;
    logic [10:0]   sep_num_count = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic [7:0]    m_row, m_col;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic [7:0]    dim_rows, dim_cols;
    logic          clear = 1'b0;
    logic          busy, done, error;
    logic [1:0]    err_code;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            saw_valid = 1'b0;

    num_matrix_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(32)) dut (
        .clk(clk), .rst(rst), .sep_done(sep_done), .sep_invalid(sep_invalid),
        .sep_num_count(sep_num_count), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_row(m_row), .m_col(m_col), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .dim_rows(dim_rows), .dim_cols(dim_cols),
        .clear(clear), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) if (m_valid) saw_valid = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mat(input int rows, input int cols);
        mem[0] = 32'(rows);
        mem[1] = 32'(cols);
        for (int k = 0; k < rows * cols; k++) mem[2 + k] = 32'(k + 1);
        sep_num_count = 11'(2 + rows * cols);
    endtask

    task automatic push_exp(input int rows, input int cols);
        exp_t e;
`ifdef LOADER_TRANSPOSE_EN
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < rows; r++) begin
`else
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
`endif
                e.d = mem[2 + r * cols + c];
                e.r = 8'(r);
                e.c = 8'(c);
                e.l = (r == rows - 1) && (c == cols - 1);
                q.push_back(e);
            end
    endtask

    task automatic pulse_start();
        @(negedge clk) sep_done = 1'b1;
        @(negedge clk) sep_done = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    // Consume elements until done, stop_hs handshakes, or budget expires.
    // stall_idx selects an element held with m_ready=0 for 5 cycles.
    task automatic run_stream(input int stall_idx, input int stop_hs, input int budget);
        int   hs = 0;
        int   stall = 0;
        bit   fin = 1'b0;
        exp_t e;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            if (done) fin = 1'b1;
            else if (stop_hs >= 0 && hs == stop_hs) fin = 1'b1;
            else begin
                m_ready = 1'b1;
                if (m_valid && hs == stall_idx && stall < 5) begin
                    m_ready = 1'b0;
                    stall++;
                    chk("stall_data_hold", m_data, (q.size() > 0) ? q[0].d : '1);
                    chk("stall_col_hold", m_col, (q.size() > 0) ? q[0].c : '1);
                end
                if (m_valid && m_ready) begin
                    if (q.size() == 0) chk("extra_element", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("elem_data", m_data, e.d);
                        chk("elem_row", m_row, e.r);
                        chk("elem_col", m_col, e.c);
                        chk("elem_last", m_last, e.l);
                    end
                    hs++;
                end
            end
        end
        if (!fin) chk("stream_timeout", 0, 1);
    endtask

    task automatic err_case(input string tag, input int rows, input int cols,
                            input int cnt, input bit inv, input logic [1:0] code);
        mem[0] = 32'(rows);
        mem[1] = 32'(cols);
        sep_num_count = 11'(cnt);
        sep_invalid = inv;
        saw_valid = 1'b0;
        pulse_start();
        sep_invalid = 1'b0;
        for (int i = 0; i < 20 && !error; i++) @(negedge clk);
        chk({tag, "_error"}, error, 1);
        chk({tag, "_code"}, err_code, code);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_no_valid"}, saw_valid, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_code_held"}, err_code, code);
        do_clear();
        chk({tag, "_cleared"}, {error, err_code}, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_flags", {m_valid, m_last, busy, done, error, err_code}, 0);
        chk("reset_addr", rd_addr, 0);
        chk("reset_dims", {dim_rows, dim_cols, m_row, m_col}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 2x3 load with m_ready held high
        load_mat(2, 3);
        push_exp(2, 3);
        pulse_start();
        run_stream(-1, -1, 200);
        chk("basic_done", done, 1);
        chk("basic_err_code", {error, err_code}, 0);
        chk("basic_dims", {dim_rows, dim_cols}, {8'd2, 8'd3});
        chk("basic_valid_low", m_valid, 0);
        chk("basic_queue_empty", q.size(), 0);
        do_clear();
        chk("basic_cleared", {done, busy}, 0);

        // Error paths
        err_case("invalid", 2, 3, 8, 1'b1, 2'b01);
        err_case("rows_zero", 0, 4, 2, 1'b0, 2'b10);
        err_case("rows_big", 33, 1, 35, 1'b0, 2'b10);
        err_case("count_bad", 2, 2, 5, 1'b0, 2'b11);

        // Backpressure on element 2
        load_mat(2, 3);
        push_exp(2, 3);
        pulse_start();
        run_stream(1, -1, 300);
        chk("stall_done", done, 1);
        chk("stall_queue_empty", q.size(), 0);
        do_clear();

        // Reset during element 4, then restart with sep_done held across reset
        push_exp(2, 3);
        pulse_start();
        run_stream(-1, 3, 200);
        for (int i = 0; i < 10 && !m_valid; i++) @(negedge clk);
        chk("elem4_valid", m_valid, 1);
        chk("elem4_data", m_data, 4);
        rst = 1'b1;
        sep_done = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_flags", {m_valid, m_last, busy, done, error, err_code}, 0);
        chk("midrst_regs", {m_row, m_col, dim_rows, dim_cols}, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_addr", rd_addr, 0);
        q.delete();
        @(negedge clk) rst = 1'b0;
        push_exp(2, 3);
        run_stream(-1, -1, 300);
        chk("restart_done", done, 1);
        chk("restart_queue_empty", q.size(), 0);
        do_clear();
        repeat (6) @(negedge clk);
        chk("no_second_start", {busy, done, error}, 0);
        sep_done = 1'b0;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/num_matrix_loader.md
NUM_MATRIX_LOADER -- requirements
Module: num_matrix_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: RAM word / element width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11: number-RAM address width.
REQ-003 SHALL have parameter MAX_DIM, default 32: largest legal row or column count.
REQ-004 SHALL have port clk  in  1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port sep_done  in  1: separator finished, all numbers in RAM.
REQ-007 SHALL have port sep_invalid  in  1: separator rejected the payload.
REQ-008 SHALL have port sep_num_count  in  11: numbers stored by the separator.
REQ-009 SHALL have port rd_addr  out  ADDR_WIDTH: number-RAM read address.
REQ-010 SHALL have port rd_data  in  DATA_WIDTH: RAM data, valid 1 cycle after rd_addr.
REQ-011 SHALL have port m_data  out  DATA_WIDTH: element value.
REQ-012 SHALL have port m_row / m_col  out  8 each: element indices.
REQ-013 SHALL have port m_valid  out  1, m_ready  in  1, m_last  out  1: element stream handshake.
REQ-014 SHALL have port dim_rows / dim_cols  out  8 each: latched header dimensions.
REQ-015 SHALL have port clear  in  1: return from DONE/ERR to IDLE.
REQ-016 SHALL have port busy, done, error  out  1 each; err_code  out  2.

Function
REQ-017 SHALL use the FSM states IDLE, HDR0, HDR1, CHECK, FETCH, CAP, OUT, DONE and ERR.
REQ-018 SHALL start in IDLE on a sep_done rising edge (registered previous value reset to 0); sep_invalid=1 at that edge -> ERR with err_code=01.
REQ-019 SHALL read the header in HDR0/HDR1: addr 0 -> dim_rows (low 8 bits), addr 1 -> dim_cols, each captured the cycle after the address is driven.
REQ-020 SHALL, in CHECK, go to ERR code=10 if rows or cols is 0 or exceeds MAX_DIM, else ERR code=11 if sep_num_count != 2+rows*cols (11-bit product, no truncation), else FETCH.
REQ-021 SHALL drive rd_addr = 2 + row*cols + col in FETCH, load m_data from rd_data in CAP, and assert m_valid throughout OUT.
REQ-022 SHALL hold m_data, m_row, m_col and m_last stable while m_valid=1 and m_ready=0.
REQ-023 SHALL, on an OUT handshake: col==cols-1 wraps col to 0 and increments row, otherwise increments col; the last element goes to DONE, otherwise FETCH.
REQ-024 SHALL assert m_last only on element (rows-1, cols-1); minimum 3 cycles per element.
REQ-025 SHALL keep busy=1 in HDR0..OUT; done=1 only in DONE; error=1 only in ERR, with err_code held.
REQ-026 SHALL exit DONE/ERR to IDLE only on clear=1, and SHALL ignore clear in other states.
REQ-027 SHALL ignore sep_done edges outside IDLE.
REQ-028 SHALL keep m_valid=0 in every state except OUT.

Reset
REQ-029 SHALL, on rst=1 at any time (including mid-stream), immediately enter IDLE and zero all outputs, counters, dims and the sep_done edge register.
REQ-030 SHALL accept a sep_done held high across reset release as one new start.

Configuration
REQ-031 SHALL, when LOADER_TRANSPOSE_EN is defined, emit elements column-major: row is the inner counter and wraps at rows-1, col increments on the wrap, and the address is unchanged as 2+row*cols+col.
REQ-032 SHALL, when LOADER_TRANSPOSE_EN is undefined, emit elements row-major as in REQ-023; m_last is (rows-1, cols-1) in both modes.

Verification
REQ-033 SHALL cover: RAM {2,3,1,2,3,4,5,6}, count=8, m_ready=1 -> data 1..6, (row,col) (0,0)..(1,2), m_last on 6th, then done=1, err_code=00.
REQ-034 SHALL cover: sep_done rising edge with sep_invalid=1 -> error=1, err_code=01, m_valid never asserted; clear=1 -> IDLE.
REQ-035 SHALL cover: header {0,4} and header {33,1} -> err_code=10; header {2,2} with count=5 -> err_code=11.
REQ-036 SHALL cover: m_ready=0 for 5 cycles on element 2 of REQ-033 -> m_data=2 held, no element skipped or duplicated.
REQ-037 SHALL cover: rst pulse during element 4 -> all outputs 0 next edge; restart via sep_done edge -> full 1..6 sequence.
REQ-038 SHALL cover: LOADER_TRANSPOSE_EN with REQ-033 data -> sequence 1,4,2,5,3,6, m_last on 6.
